tpu_top: RTL and testbench



---
 rtl/tpu_top_if.sv | 11 +
 rtl/tpu_top.sv | 169 ++++++++++++++++
 tb/tb_tpu_top.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_top_if.sv
// rtl/tpu_top_if.sv - layer start/mode/finish handshake between host and TPU core
interface tpu_top_if;
    logic       start_i;
    logic [3:0] mode_i;
    logic       finish_o;

    // Host drives start/mode and watches finish.
    modport master (output start_i, output mode_i, input finish_o);
    // TPU core consumes start/mode and reports finish.
    modport slave  (input start_i, input mode_i, output finish_o);
endinterface

// File: rtl/tpu_top.sv
// rtl/tpu_top.sv - int8 TPU layer engine (FC / 3x3 conv) with input, weight/bias and output SRAMs; optional OUT_RELU_EN
module tpu_top #(
    parameter int MEM_WORDS   = 32768,
    parameter int WEIGHT_BASE = 1024,
    parameter int IN_DIM      = 64,
    parameter int OUT_DIM     = 16,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int SHIFT       = 7
) (
    input  logic       clk,
    input  logic       rstn,
    tpu_top_if.slave   ctrl
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef logic [AW-1:0] addr_t;

    localparam addr_t WB    = addr_t'(WEIGHT_BASE);
    localparam addr_t IDM   = addr_t'(IN_DIM);
    localparam addr_t ODM   = addr_t'(OUT_DIM);
    localparam addr_t IW    = addr_t'(IMG_W);
    localparam addr_t OW    = addr_t'(IMG_W - 2);
    localparam addr_t OH    = addr_t'(IMG_H - 2);
    localparam addr_t NINE  = addr_t'(9);
    localparam addr_t THREE = addr_t'(3);
    localparam addr_t TWO   = addr_t'(2);
    localparam addr_t ONE   = addr_t'(1);
    localparam logic signed [31:0] RND = 32'sd1 <<< (SHIFT - 1);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

    // SRAM arrays; in_mem and wb_mem are loaded by the host side.
    logic [15:0] in_mem  [0:MEM_WORDS-1];
    logic [15:0] wb_mem  [0:MEM_WORDS-1];
    logic [15:0] out_mem [0:MEM_WORDS-1];

    state_t             state;
    logic               is_fc;
    addr_t              c, y, x, ky, kx, k, o;
    logic signed [31:0] acc;
    logic [15:0]        in_rdata, wb_rdata;

    addr_t              in_addr, w_addr, wb_addr, k_max;
    logic               last_out;
    logic signed [15:0] in_s, w_s, prod;
    logic signed [31:0] rnd_sum, shifted;
    logic [7:0]         sat8;
    logic [15:0]        out_word;

    // Tap addressing: the read for tap k is issued in MAC cycle k, data is used in cycle k+1.
    always_comb begin
        in_addr = '0;
        w_addr  = '0;
        if (is_fc) begin
            in_addr = k;
            w_addr  = WB + c * IDM + k;
        end else begin
            in_addr = (y + ky) * IW + x + kx;
            w_addr  = WB + c * NINE + ky * THREE + kx;
        end
        wb_addr  = (state == S_BIAS) ? c : w_addr;
        k_max    = is_fc ? IDM : NINE;
        last_out = is_fc ? (c == ODM - ONE)
                         : (c == ODM - ONE) && (y == OH - ONE) && (x == OW - ONE);
    end

    // Signed 8x8 product of the current read data; fits in 16 bits.
    always_comb begin
        in_s = {{8{in_rdata[7]}}, in_rdata[7:0]};
        w_s  = {{8{wb_rdata[7]}}, wb_rdata[7:0]};
        prod = in_s * w_s;
    end

    // Round-half-up requantisation followed by clamp to int8.
    always_comb begin
        rnd_sum = acc + RND;
        shifted = rnd_sum >>> SHIFT;
`ifdef OUT_RELU_EN
        if (shifted < 0) shifted = '0;
`endif
        if (shifted > 32'sd127)       sat8 = 8'h7F;
        else if (shifted < -32'sd128) sat8 = 8'h80;
        else                          sat8 = shifted[7:0];
        out_word = {{8{sat8[7]}}, sat8};
    end

    // Input and weight/bias SRAM read ports, one cycle latency.
    always_ff @(posedge clk) begin
        in_rdata <= in_mem[in_addr];
        wb_rdata <= wb_mem[wb_addr];
    end

    // Output SRAM write port.
    always_ff @(posedge clk) begin
        if (state == S_WRITE) out_mem[o] <= out_word;
    end

    // Layer controller: bias load, K taps, write, then next output or done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            ctrl.finish_o <= 1'b0;
            is_fc         <= 1'b0;
            c  <= '0; y  <= '0; x <= '0;
            ky <= '0; kx <= '0; k <= '0; o <= '0;
            acc           <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) ctrl.finish_o <= 1'b1;
                    state <= S_IDLE;
                    if (ctrl.start_i) begin
                        ctrl.finish_o <= 1'b0;
                        c  <= '0; y  <= '0; x <= '0;
                        ky <= '0; kx <= '0; k <= '0; o <= '0;
                        if (ctrl.mode_i == 4'b0010) begin
                            is_fc <= 1'b0;
                            state <= S_BIAS;
                        end else if (ctrl.mode_i == 4'b0100) begin
                            is_fc <= 1'b1;
                            state <= S_BIAS;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_BIAS: begin
                    k     <= '0;
                    ky    <= '0;
                    kx    <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (k == '0) acc <= {{16{wb_rdata[15]}}, wb_rdata};
                    else         acc <= acc + {{16{prod[15]}}, prod};
                    if (k == k_max) begin
                        state <= S_WRITE;
                    end else begin
                        k <= k + ONE;
                        if (kx == TWO) begin
                            kx <= '0;
                            ky <= ky + ONE;
                        end else begin
                            kx <= kx + ONE;
                        end
                    end
                end
                S_WRITE: begin
                    o     <= o + ONE;
                    state <= last_out ? S_DONE : S_BIAS;
                    if (is_fc) begin
                        c <= c + ONE;
                    end else if (x == OW - ONE) begin
                        x <= '0;
                        if (y == OH - ONE) begin
                            y <= '0;
                            c <= c + ONE;
                        end else begin
                            y <= y + ONE;
                        end
                    end else begin
                        x <= x + ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_top.sv
// tb/tb_tpu_top.sv - self-checking bench for tpu_top against an arithmetic layer model
module tb_tpu_top;
    localparam int MEM_WORDS   = 32768;
    localparam int WEIGHT_BASE = 1024;
    localparam int IN_DIM      = 64;
    localparam int OUT_DIM     = 16;
    localparam int IMG_W       = 8;
    localparam int IMG_H       = 8;
    localparam int SHIFT       = 7;
    localparam int OW       = IMG_W - 2;
    localparam int OH       = IMG_H - 2;
    localparam int NCONV    = OUT_DIM * OW * OH;
    localparam int IN_LEN   = (IN_DIM > IMG_W * IMG_H) ? IN_DIM : IMG_W * IMG_H;
    localparam int W_LEN    = OUT_DIM * IN_DIM;
    localparam int FC_CYC   = OUT_DIM * (IN_DIM + 3) + 1;
    localparam int CONV_CYC = NCONV * (9 + 3) + 1;
    localparam int BUDGET   = 20000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    tpu_top_if bus ();

    always #5 clk = ~clk;

    tpu_top #(
        .MEM_WORDS(MEM_WORDS), .WEIGHT_BASE(WEIGHT_BASE), .IN_DIM(IN_DIM),
        .OUT_DIM(OUT_DIM), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .ctrl (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          in_v [0:IN_LEN-1];
    int          w_v  [0:W_LEN-1];
    int          b_v  [0:OUT_DIM-1];
    logic [15:0] exp_o [0:NCONV-1];
    logic [15:0] snap  [0:3];
    logic [3:0]  bad_modes [0:3] = '{4'b0001, 4'b0110, 4'b0000, 4'b1000};
    logic [15:0] snap_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] requant(input int acc);
        int r;
        r = (acc + (1 <<< (SHIFT - 1))) >>> SHIFT;
`ifdef OUT_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return 16'(r);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Data lives in bits[7:0]; upper byte is junk the engine must ignore.
    task automatic load_mems();
        for (int i = 0; i < IN_LEN; i++) dut.in_mem[i] = {8'($urandom), 8'(in_v[i])};
        for (int i = 0; i < W_LEN; i++)  dut.wb_mem[WEIGHT_BASE + i] = {8'($urandom), 8'(w_v[i])};
        for (int j = 0; j < OUT_DIM; j++) dut.wb_mem[j] = 16'(b_v[j]);
    endtask

    task automatic model_fc();
        for (int j = 0; j < OUT_DIM; j++) begin
            int acc = b_v[j];
            for (int i = 0; i < IN_DIM; i++) acc += in_v[i] * w_v[j * IN_DIM + i];
            exp_o[j] = requant(acc);
        end
    endtask

    task automatic model_conv();
        for (int ch = 0; ch < OUT_DIM; ch++)
            for (int py = 0; py < OH; py++)
                for (int px = 0; px < OW; px++) begin
                    int acc = b_v[ch];
                    for (int t = 0; t < 9; t++)
                        acc += in_v[(py + t / 3) * IMG_W + px + t % 3] * w_v[ch * 9 + t];
                    exp_o[ch * OW * OH + py * OW + px] = requant(acc);
                end
    endtask

    task automatic start_layer(input logic [3:0] m);
        @(negedge clk);
        bus.mode_i  = m;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("finish_clr", {31'd0, bus.finish_o}, 32'd0);
    endtask

    task automatic wait_finish(input string tag, input int exp_cyc);
        int n = 0;
        while (bus.finish_o !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp_cyc);
    endtask

    task automatic check_out(input string tag, input int n);
        for (int i = 0; i < n; i++) chk(tag, {16'd0, dut.out_mem[i]}, {16'd0, exp_o[i]});
    endtask

    task automatic rand_fc();
        for (int i = 0; i < IN_LEN; i++) in_v[i] = rnd8();
        for (int i = 0; i < W_LEN; i++)  w_v[i] = rnd8();
        for (int j = 0; j < OUT_DIM; j++) b_v[j] = int'($urandom_range(0, 65535)) - 32768;
        load_mems();
        model_fc();
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.mode_i  = 4'b0001;
        repeat (3) @(negedge clk);
        chk("rst_finish", {31'd0, bus.finish_o}, 32'd0);
        rstn = 1'b1;

        // FC with all ones: every output is exactly 1.
        for (int i = 0; i < IN_LEN; i++) in_v[i] = 1;
        for (int i = 0; i < W_LEN; i++)  w_v[i] = 1;
        for (int j = 0; j < OUT_DIM; j++) b_v[j] = 0;
        load_mems();
        model_fc();
        snap_hi = dut.out_mem[OUT_DIM];
        start_layer(4'b0100);
        wait_finish("fc1_cycles", FC_CYC);
        check_out("fc1_out", OUT_DIM);
        chk("fc1_const0", {16'd0, dut.out_mem[0]}, 32'h0001);
        chk("fc1_const15", {16'd0, dut.out_mem[OUT_DIM-1]}, 32'h0001);
        chk("fc1_nowrite", {16'd0, dut.out_mem[OUT_DIM]}, {16'd0, snap_hi});
        repeat (10) @(negedge clk);
        chk("finish_hold", {31'd0, bus.finish_o}, 32'd1);

        // Asynchronous reset clears finish without a clock edge.
        #2 rstn = 1'b0;
        #1 chk("async_rst", {31'd0, bus.finish_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Positive and negative saturation.
        for (int i = 0; i < IN_LEN; i++) in_v[i] = 127;
        for (int i = 0; i < W_LEN; i++)  w_v[i] = 127;
        for (int j = 0; j < OUT_DIM; j++) b_v[j] = 32767;
        load_mems();
        model_fc();
        start_layer(4'b0100);
        wait_finish("satp_cycles", FC_CYC);
        check_out("satp_out", OUT_DIM);
        chk("satp_const", {16'd0, dut.out_mem[3]}, 32'h007F);
        for (int i = 0; i < W_LEN; i++) w_v[i] = -128;
        load_mems();
        model_fc();
        start_layer(4'b0100);
        wait_finish("satn_cycles", FC_CYC);
        check_out("satn_out", OUT_DIM);
`ifdef OUT_RELU_EN
        chk("satn_const", {16'd0, dut.out_mem[5]}, 32'h0000);
`else
        chk("satn_const", {16'd0, dut.out_mem[5]}, 32'hFF80);
`endif

        // Random FC layers.
        for (int r = 0; r < 2; r++) begin
            rand_fc();
            start_layer(4'b0100);
            wait_finish("fcr_cycles", FC_CYC);
            check_out("fcr_out", OUT_DIM);
        end

        // Conv: pixel index mod 5, all-ones kernel, bias 64.
        for (int i = 0; i < IN_LEN; i++) in_v[i] = i % 5;
        for (int i = 0; i < W_LEN; i++)  w_v[i] = 1;
        for (int j = 0; j < OUT_DIM; j++) b_v[j] = 64;
        load_mems();
        model_conv();
        snap_hi = dut.out_mem[NCONV];
        start_layer(4'b0010);
        wait_finish("conv1_cycles", CONV_CYC);
        check_out("conv1_out", NCONV);
        chk("conv1_nowrite", {16'd0, dut.out_mem[NCONV]}, {16'd0, snap_hi});

        // Random conv.
        for (int i = 0; i < IN_LEN; i++) in_v[i] = rnd8();
        for (int i = 0; i < W_LEN; i++)  w_v[i] = rnd8();
        for (int j = 0; j < OUT_DIM; j++) b_v[j] = int'($urandom_range(0, 4095)) - 2048;
        load_mems();
        model_conv();
        start_layer(4'b0010);
        wait_finish("convr_cycles", CONV_CYC);
        check_out("convr_out", NCONV);

        // Invalid modes finish quickly and leave out_mem alone.
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) snap[i] = dut.out_mem[i];
            start_layer(bad_modes[m]);
            wait_finish("badmode_cycles", 1);
            for (int i = 0; i < 4; i++)
                chk("badmode_nowrite", {16'd0, dut.out_mem[i]}, {16'd0, snap[i]});
        end

        // A start pulse while busy is ignored; mode is latched at start.
        rand_fc();
        start_layer(4'b0100);
        repeat (20) @(negedge clk);
        bus.mode_i  = 4'b0010;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_finish("busy_cycles", FC_CYC - 21);
        check_out("busy_out", OUT_DIM);

        // Re-start after finish reproduces the same results.
        start_layer(4'b0100);
        wait_finish("rerun_cycles", FC_CYC);
        check_out("rerun_out", OUT_DIM);

        // Reset mid-MAC aborts; FSM stays idle until the next start.
        rand_fc();
        start_layer(4'b0100);
        repeat (150) @(negedge clk);
        rstn = 1'b0;
        #1 chk("midrst_finish", {31'd0, bus.finish_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (FC_CYC + 50) @(negedge clk);
        chk("midrst_idle", {31'd0, bus.finish_o}, 32'd0);
        start_layer(4'b0100);
        wait_finish("midrst_cycles", FC_CYC);
        check_out("midrst_out", OUT_DIM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
